// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch front end for a byte-wide CPU. It reads an opcode byte from
// memory, reads a second operand byte when the opcode MSB is set, and presents
// the instruction to the control unit until it is accepted. A redirect
// (jump/branch) flushes whatever is in flight. A read that waits too long for
// its acknowledge parks the unit in a sticky fault state until redirected.
//
// Parameters
//   BITS      data and address width
//   RESET_PC  fetch address loaded at reset
//   TIMEOUT   max consecutive cycles a read may wait for i_mem_ack
//
// Ports
//   i_clk        clock, all state changes on the rising edge
//   i_rst_n      asynchronous active-low reset
//   o_mem_addr   memory read address (internal fetch pointer)
//   o_mem_rd     read request, high only while fetching a byte
//   i_mem_data   read data, valid with i_mem_ack
//   i_mem_ack    read completion strobe (ignored when o_mem_rd=0)
//   o_opcode     fetched opcode byte
//   o_operand    fetched operand byte, 0 for one-byte instructions
//   o_valid      instruction held and presented
//   i_ready      control unit accepts the presented instruction
//   o_pc         address of the opcode byte held or being fetched
//   i_ld_pc      redirect request
//   i_pc_target  redirect address
//   o_fault      sticky memory-timeout flag
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter int unsigned     BITS     = 8,
  parameter logic [BITS-1:0] RESET_PC = '0,
  parameter int unsigned     TIMEOUT  = 15
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  output logic [BITS-1:0] o_mem_addr,
  output logic            o_mem_rd,
  input  logic [BITS-1:0] i_mem_data,
  input  logic            i_mem_ack,
  output logic [BITS-1:0] o_opcode,
  output logic [BITS-1:0] o_operand,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [BITS-1:0] o_pc,
  input  logic            i_ld_pc,
  input  logic [BITS-1:0] i_pc_target,
  output logic            o_fault
);

  // Wide enough to hold TIMEOUT itself, even though it never exceeds TIMEOUT-1.
  localparam int unsigned     WAIT_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    StFetchOp,
    StFetchArg,
    StHold,
    StFlush,
    StFault
  } state_e;

  state_e            r_state;
  logic [BITS-1:0]   r_ptr;
  logic [BITS-1:0]   r_pc;
  logic [BITS-1:0]   r_opcode;
  logic [BITS-1:0]   r_operand;
  logic              r_valid;
  logic              r_fault;
  logic [WAIT_W-1:0] r_wait;

  logic              w_fetching;
  logic              w_ack;
  logic              w_timeout;
  logic [BITS-1:0]   w_ptr_inc;
  logic              w_two_byte;

  // Pointer arithmetic wraps naturally modulo 2^BITS.
  assign w_ptr_inc  = r_ptr + BITS'(1);
  assign w_fetching = (r_state == StFetchOp) || (r_state == StFetchArg);
  // An ack only counts while a read is actually outstanding.
  assign w_ack      = i_mem_ack && w_fetching;
  // This no-ack cycle is the TIMEOUT-th consecutive one.
  assign w_timeout  = (r_wait == WAIT_LAST);
  assign w_two_byte = i_mem_data[BITS-1];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= StFetchOp;
      r_ptr     <= RESET_PC;
      r_pc      <= RESET_PC;
      r_opcode  <= '0;
      r_operand <= '0;
      r_valid   <= 1'b0;
      r_fault   <= 1'b0;
      r_wait    <= '0;
    end else if (i_ld_pc) begin
      // Redirect wins over ack, accept and timeout in every state.
      r_state <= StFlush;
      r_ptr   <= i_pc_target;
      r_pc    <= i_pc_target;
      r_valid <= 1'b0;
      r_fault <= 1'b0;
      r_wait  <= '0;
    end else begin
      case (r_state)
        StFetchOp: begin
          if (w_ack) begin
            r_opcode <= i_mem_data;
            r_pc     <= r_ptr;
            r_ptr    <= w_ptr_inc;
            r_wait   <= '0;
            if (w_two_byte) begin
              r_state <= StFetchArg;
            end else begin
              r_operand <= '0;
              r_valid   <= 1'b1;
              r_state   <= StHold;
            end
          end else if (w_timeout) begin
            r_state <= StFault;
            r_fault <= 1'b1;
            r_wait  <= '0;
          end else begin
            r_wait <= r_wait + WAIT_W'(1);
          end
        end

        StFetchArg: begin
          if (w_ack) begin
            r_operand <= i_mem_data;
            r_ptr     <= w_ptr_inc;
            r_wait    <= '0;
            r_valid   <= 1'b1;
            r_state   <= StHold;
          end else if (w_timeout) begin
            r_state <= StFault;
            r_fault <= 1'b1;
            r_wait  <= '0;
          end else begin
            r_wait <= r_wait + WAIT_W'(1);
          end
        end

        StHold: begin
          if (i_ready) begin
            // o_pc tracks the opcode address of the fetch that starts now.
            r_valid <= 1'b0;
            r_pc    <= r_ptr;
            r_state <= StFetchOp;
          end
        end

        StFlush: begin
          r_state <= StFetchOp;
        end

        StFault: begin
          r_state <= StFault;
        end

        default: begin
          r_state <= StFetchOp;
          r_valid <= 1'b0;
          r_wait  <= '0;
        end
      endcase
    end
  end

  // Gated by reset so no read is requested while the unit is held in reset.
  assign o_mem_rd   = i_rst_n && w_fetching;
  assign o_mem_addr = r_ptr;
  assign o_opcode   = r_opcode;
  assign o_operand  = r_operand;
  assign o_valid    = r_valid;
  assign o_pc       = r_pc;
  assign o_fault    = r_fault;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter BITS, 8, data and address width.
REQ-002 Parameter RESET_PC, 0, fetch address loaded at reset.
REQ-003 Parameter TIMEOUT, 15, max cycles o_mem_rd may wait for i_mem_ack.
REQ-004 i_clk  input  1  single clock; all state changes on rising edge.
REQ-005 i_rst_n  input  1  reset; asynchronous, active-low.
REQ-006 o_mem_addr  output  BITS  memory read address.
REQ-007 o_mem_rd  output  1  read request.
REQ-008 i_mem_data  input  BITS  read data, valid when i_mem_ack=1.
REQ-009 i_mem_ack  input  1  read completion strobe.
REQ-010 o_opcode  output  BITS  fetched opcode byte, consumed by the control unit.
REQ-011 o_operand  output  BITS  fetched operand byte; 0 for one-byte instructions.
REQ-012 o_valid  output  1  instruction held and presented.
REQ-013 i_ready  input  1  control unit accepts the presented instruction.
REQ-014 o_pc  output  BITS  address of the opcode byte currently held or being fetched.
REQ-015 i_ld_pc  input  1  redirect request (jump/branch).
REQ-016 i_pc_target  input  BITS  redirect address.
REQ-017 o_fault  output  1  sticky memory-timeout flag.

Function
REQ-018 States SHALL be FETCH_OP, FETCH_ARG, HOLD, FLUSH, FAULT.
REQ-019 o_mem_rd SHALL be 1 exactly in FETCH_OP and FETCH_ARG; o_mem_addr SHALL equal the internal fetch pointer and stay stable while o_mem_rd=1 and no ack.
REQ-020 FETCH_OP, i_mem_ack=1: o_opcode<=i_mem_data, o_pc<=pointer, pointer+1 (mod 2^BITS); next FETCH_ARG if i_mem_data[BITS-1]=1, else o_operand<=0 and next HOLD.
REQ-021 FETCH_ARG, i_mem_ack=1: o_operand<=i_mem_data, pointer+1 (mod 2^BITS), next HOLD.
REQ-022 Minimum latency: one-byte instruction o_valid 1 cycle after the ack edge; two-byte requires two acks.
REQ-023 HOLD: o_valid=1; o_opcode, o_operand, o_pc stable until i_ready=1 sampled; then next FETCH_OP, o_valid=0 next cycle.
REQ-024 i_mem_ack with o_mem_rd=0 (HOLD, FLUSH, FAULT) SHALL be ignored.
REQ-025 Wait counter SHALL count consecutive o_mem_rd=1 cycles without ack, clear on ack or state change; reaching TIMEOUT -> FAULT, o_fault<=1.
REQ-026 FAULT: o_mem_rd=0, o_valid=0; exit only via i_ld_pc or reset.
REQ-027 i_ld_pc=1 in any state SHALL take priority over ack, i_ready and timeout: pointer<=i_pc_target, o_valid<=0, o_fault<=0, wait counter<=0, next FLUSH; a same-cycle ack is discarded.
REQ-028 FLUSH SHALL last exactly one cycle (o_mem_rd=0), then FETCH_OP; o_pc SHALL equal i_pc_target from FLUSH onward.
REQ-029 i_ld_pc asserted in FLUSH SHALL reload pointer and remain in FLUSH one more cycle.
REQ-030 Pointer wrap: 2^BITS-1 + 1 -> 0, no flag.

Reset
REQ-031 While i_rst_n=0: state FETCH_OP, pointer and o_pc = RESET_PC, o_opcode=0, o_operand=0, o_valid=0, o_fault=0, wait counter 0, o_mem_rd forced 0.
REQ-032 Reset asserted mid-read or in HOLD SHALL abort immediately; first read after release at RESET_PC.

Verification
REQ-033 Reset release, mem[0]=0x12, ack after 2 waits -> o_opcode=0x12, o_operand=0, o_pc=0, o_valid=1 while i_ready=0; next read at 0x01 after i_ready=1.
REQ-034 mem[0x05]=0x83, mem[0x06]=0x40, pointer 0x05 -> o_opcode=0x83, o_operand=0x40, o_pc=0x05; next fetch addr 0x07.
REQ-035 Ack withheld 15 cycles -> o_fault=1, o_mem_rd=0; i_ld_pc with target 0x20 -> o_fault=0, one FLUSH cycle, read at 0x20.
REQ-036 i_ld_pc (target 0x30) same cycle as i_mem_ack in FETCH_ARG -> data discarded, o_valid stays 0, next read at 0x30.
REQ-037 Pointer 0xFF, two-byte opcode 0x81 -> operand read at 0x00, next opcode read at 0x01.
REQ-038 Reset asserted during HOLD with o_valid=1 -> o_valid=0 immediately; after release read at RESET_PC.
